// File: rtl/mod_mul_arb.sv
// Two-requester round-robin arbiter wrapped around a repeated-addition multiplier.
// One job at a time: capture operands, accumulate X for Y iterations, strobe the tagged product.
module mod_mul_arb #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             done_id,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a requester holds reqN high with stable operands until it sees a
    // one-cycle gntN pulse; the operands are already captured when gntN is high.
    // valid is a one-cycle strobe qualifying out and done_id.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cnt;
    logic             owner;
    logic             last;

    logic             any_req;
    logic             sel;
    logic             run_done;

    assign any_req  = req0 | req1;
    // On a tie the requester that was not served last wins.
    assign sel      = (req0 & req1) ? ~last : req1;
    assign run_done = (cnt == yr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   state_nxt = RUN;
            RUN:     if (run_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0      = (state == GRANT) && !owner;
        gnt1      = (state == GRANT) &&  owner;
        valid     = (state == DONE);
        busy      = (state != IDLE);
        state_dbg = state;
    end

    // LAST resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xr      <= '0;
            yr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            owner   <= 1'b0;
            last    <= 1'b1;
            out     <= '0;
            done_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        xr    <= sel ? x1 : x0;
                        yr    <= sel ? y1 : y0;
                        acc   <= '0;
                        cnt   <= '0;
                        owner <= sel;
                    end
                end
                GRANT: last <= owner;
                RUN: begin
                    if (run_done) begin
                        out     <= acc;
                        done_id <= owner;
                    end else begin
                        acc <= acc + xr;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
